// File: rtl/fp_div_round_pack.sv
// Round/pack back end of the binary32 divider.
// Two valid/ready stages: normalize/denormalize, then round, pack and flag.
module fp_div_round_pack #(
    parameter int unsigned EXP_W = 10,
    parameter int unsigned SIG_W = 27
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic signed [EXP_W-1:0] in_exp,
    input  logic [SIG_W-1:0]        in_sig,
    input  logic [1:0]              in_special,
    input  logic                    in_dz,
    input  logic                    in_nv,
    input  logic [2:0]              in_rm,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_result,
    output logic [4:0]              out_flags
);

    localparam int unsigned MAN_W = 24;
    localparam int unsigned SH_W  = $clog2(SIG_W + 1);
    localparam int unsigned GRD_B = SIG_W - MAN_W - 1;

    localparam logic [1:0] CLS_NORMAL = 2'b00;
    localparam logic [1:0] CLS_ZERO   = 2'b01;
    localparam logic [1:0] CLS_INF    = 2'b10;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    typedef struct packed {
        logic             sign;
        logic [2:0]       rm;
        logic [1:0]       special;
        logic             nv;
        logic             dz;
        logic             tiny;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] kept;
        logic             guard;
        logic             sticky;
    } stage1T;

    logic   s1Valid;
    stage1T s1Q;
    stage1T s1Next;
    logic   s1En;
    logic   s2En;

    assign s2En     = !out_valid || out_ready;
    assign s1En     = !s1Valid || s2En;
    assign in_ready = s1En;

    // Stage 1: bring the leading one to the top bit, or denormalize into a subnormal.
    logic signed [EXP_W:0] expAdj;
    logic [EXP_W:0]        shRaw;
    logic [SH_W-1:0]       shAmt;
    logic [SIG_W-1:0]      sigNorm;
    logic [SIG_W-1:0]      lostMask;
    logic [SIG_W-1:0]      sigSel;
    logic                  tiny;

    always_comb begin
        sigNorm  = in_sig[SIG_W-1] ? in_sig : (in_sig << 1);
        expAdj   = {in_exp[EXP_W-1], in_exp} - (EXP_W+1)'(!in_sig[SIG_W-1]);
        tiny     = expAdj[EXP_W] || (expAdj == '0);
        shRaw    = (EXP_W+1)'(1) - expAdj;
        shAmt    = (shRaw >= (EXP_W+1)'(SIG_W)) ? SH_W'(SIG_W) : shRaw[SH_W-1:0];
        lostMask = ~({SIG_W{1'b1}} << shAmt);
        sigSel   = sigNorm;
        if (tiny) begin
            sigSel = (sigNorm >> shAmt) | SIG_W'(|(sigNorm & lostMask));
        end

        s1Next         = '0;
        s1Next.sign    = in_sign;
        s1Next.rm      = in_rm;
        s1Next.special = in_special;
        s1Next.nv      = in_nv;
        s1Next.dz      = in_dz;
        s1Next.tiny    = tiny;
        s1Next.exp     = tiny ? '0 : expAdj[EXP_W-1:0];
        s1Next.kept    = sigSel[SIG_W-1 -: MAN_W];
        s1Next.guard   = sigSel[GRD_B];
        s1Next.sticky  = |sigSel[GRD_B-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid <= 1'b0;
            s1Q     <= '0;
        end else if (s1En) begin
            s1Valid <= in_valid;
            if (in_valid) begin
                s1Q <= s1Next;
            end
        end
    end

    // Stage 2: round, renormalize on carry, saturate on overflow, pack.
    logic             inc;
    logic             inexact;
    logic             ofToInf;
    logic             overflow;
    logic [MAN_W:0]   mantSum;
    logic [MAN_W-1:0] mantFin;
    logic [EXP_W:0]   expFin;
    logic [31:0]      resNext;
    logic [4:0]       flagsNext;

    always_comb begin
        inexact = s1Q.guard || s1Q.sticky;
        inc     = 1'b0;
        ofToInf = 1'b0;
        case (s1Q.rm)
            RM_RNE: begin
                inc     = s1Q.guard && (s1Q.sticky || s1Q.kept[0]);
                ofToInf = 1'b1;
            end
            RM_RTZ: inc = 1'b0;
            RM_RDN: begin
                inc     = s1Q.sign && inexact;
                ofToInf = s1Q.sign;
            end
            RM_RUP: begin
                inc     = !s1Q.sign && inexact;
                ofToInf = !s1Q.sign;
            end
            RM_RMM: begin
                inc     = s1Q.guard;
                ofToInf = 1'b1;
            end
            default: inc = 1'b0;
        endcase

        mantSum = {1'b0, s1Q.kept} + (MAN_W+1)'(inc);
        mantFin = mantSum[MAN_W] ? mantSum[MAN_W:1] : mantSum[MAN_W-1:0];
        // A subnormal that rounds into the hidden bit becomes the smallest normal.
        expFin  = s1Q.tiny ? (EXP_W+1)'(mantFin[MAN_W-1])
                           : (EXP_W+1)'(s1Q.exp) + (EXP_W+1)'(mantSum[MAN_W]);
        overflow = (expFin >= (EXP_W+1)'(255));

        resNext   = {s1Q.sign, expFin[7:0], mantFin[MAN_W-2:0]};
        flagsNext = {s1Q.nv, s1Q.dz, 1'b0, s1Q.tiny && inexact, inexact};
        if (overflow) begin
            resNext   = ofToInf ? {s1Q.sign, 8'hFF, 23'h0} : {s1Q.sign, 31'h7F7FFFFF};
            flagsNext = {s1Q.nv, s1Q.dz, 1'b1, 1'b0, 1'b1};
        end

        if (s1Q.special != CLS_NORMAL) begin
            flagsNext = {s1Q.nv, s1Q.dz, 3'b000};
            if (s1Q.special == CLS_ZERO) begin
                resNext = {s1Q.sign, 31'h0};
            end else if (s1Q.special == CLS_INF) begin
                resNext = {s1Q.sign, 8'hFF, 23'h0};
            end else begin
                resNext = 32'h7FC00000;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else if (s2En) begin
            out_valid <= s1Valid;
            if (s1Valid) begin
                out_result <= resNext;
                out_flags  <= flagsNext;
            end
        end
    end

endmodule

// File: doc/fp_div_round_pack.md
Name: fp_div_round_pack

Overview:
- Downstream stage of the single-precision divider.
- Consumes the unrounded quotient (sign, biased exponent, 27-bit significand with sticky) plus special-case class and flags.
- Normalizes, denormalizes, rounds per IEEE-754 mode, packs the binary32 result and raises exception flags.
- Two-stage valid/ready pipeline, throughput 1/cycle.

Parameters:
- EXP_W, 10, width of signed pre-round biased exponent input
- SIG_W, 27, quotient significand width (24 kept + guard + 2 sticky-class bits)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream data valid
- in_ready  out  1  stage can accept
- in_sign  in  1  result sign
- in_exp  in  EXP_W  signed two's-complement biased exponent (may be <=0 or >=255)
- in_sig  in  SIG_W  quotient significand; bit 26 or bit 25 set for normal class
- in_special  in  2  00 normal, 01 zero, 10 infinity, 11 NaN
- in_dz  in  1  divide-by-zero detected upstream
- in_nv  in  1  invalid detected upstream
- in_rm  in  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_result  out  32  packed binary32
- out_flags  out  5  {NV,DZ,OF,UF,NX}

Behaviour:
- Reset (async, rst_n low):
  - Both stage valids cleared; out_valid=0; out_result=0; out_flags=0.
  - Reset mid-flight discards all in-flight items; in_ready=1 from the first cycle after release.
- Handshake:
  - s2_en = !s2_valid | out_ready; s1_en = !s1_valid | s2_en; in_ready = s1_en.
  - Transfer on valid&ready only.
  - Latency 2 cycles with out_ready held high.
  - No loss or duplication under any backpressure pattern; order preserved.
  - out_result and out_flags are stable while out_valid & !out_ready.
- Stage 1 (normalize/denormalize), registers sign, rm, class, flags:
  - If in_sig[26]=0: sig<<1, e=in_exp-1; else e=in_exp.
  - If e<=0: shift sig right by 1-e, saturated at 27; OR all shifted-out bits into bit 0; set tiny=1; exp field=0.
  - Kept significand = sig[26:3], guard = sig[2], sticky = |sig[1:0].
- Stage 2 (round/pack):
  - inc per mode:
    - RNE: g&(s|lsb)
    - RTZ: 0
    - RDN: sign&(g|s)
    - RUP: !sign&(g|s)
    - RMM: g
  - Mantissa = kept + inc (25-bit). On carry-out: shift right 1, exp+1.
  - Subnormal whose round sets bit 23 becomes exponent 1.
  - NX = g|s.
  - UF = tiny & NX (tininess before rounding).
  - Overflow (final exp>=255): OF=1, NX=1. Result is ±inf for RNE/RMM, for RUP with positive sign, and for RDN with negative sign. Otherwise result is ±0x7F7FFFFF magnitude.
- Specials bypass rounding:
  - zero -> {sign,31'b0}
  - infinity -> {sign,8'hFF,23'b0}
  - NaN -> 32'h7FC00000
  - OF/UF/NX=0 for all three.
  - NV and DZ are passed from the inputs for every class.

Test Plan:
- Exact 1.0: in_exp=127, in_sig=27'h4000000, RNE -> 0x3F800000, flags 0, out_valid exactly 2 cycles after accept.
- RNE ties: in_sig=27'h4000004 -> 0x3F800000, NX. in_sig=27'h400000C -> 0x3F800002, NX. Same inputs under RMM -> 0x3F800001 and 0x3F800002.
- Overflow: in_exp=255, in_sig=27'h4000000, sign=0. RNE -> 0x7F800000, flags OF|NX. RTZ -> 0x7F7FFFFF, OF|NX. sign=1 with RUP -> 0xFF7FFFFF.
- Subnormal:
  - in_exp=0, in_sig=27'h4000000 -> 0x00400000, flags 0.
  - in_exp=-22, same sig -> 0x00000001, flags 0.
  - in_exp=-23 -> 0x00000000 under RNE (tie to even), UF|NX.
  - in_exp=0, in_sig=27'h7FFFFFF, RNE -> 0x00800000, UF|NX.
- Specials: NaN with nv=1 -> 0x7FC00000, NV. Infinity, sign=1, dz=1 -> 0xFF800000, DZ. Zero, sign=1 -> 0x80000000, flags 0.
- Backpressure/reset:
  - Hold out_ready=0 and offer 4 items back-to-back -> only 2 accepted, in_ready low until out_ready rises.
  - Then results emerge in order, each held stable.
  - Assert rst_n low mid-stream -> out_valid=0 immediately, no stale output after release.
